// File: rtl/ascii_seg_pkg.sv
// ascii_seg_pkg: segment patterns, ASCII constants and {g..a} bit order shared by the display driver.
package ascii_seg_pkg;
  typedef logic [6:0] seg_t;
  localparam int BIT_A = 0;
  localparam int BIT_B = 1;
  localparam int BIT_C = 2;
  localparam int BIT_D = 3;
  localparam int BIT_E = 4;
  localparam int BIT_F = 5;
  localparam int BIT_G = 6;
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_UNDERSCORE = 7'h08;
  localparam seg_t SEG_UNKNOWN = seg_t'((1 << BIT_A) | (1 << BIT_D) | (1 << BIT_G));
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam seg_t DIGIT_SEGS [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
endpackage

// File: rtl/ascii_seg_decode.sv
// ascii_seg_decode: ASCII code to active-high {g..a} segment pattern.
module ascii_seg_decode
  import ascii_seg_pkg::*;
(
  input  logic [7:0] ch,
  output logic [6:0] pat
);
  logic [7:0] lc;
  always_comb begin
    lc = (ch >= "A" && ch <= "F") ? (ch | 8'h20) : ch;
    pat = SEG_UNKNOWN;
    if (lc >= ASCII_ZERO && lc <= ASCII_ZERO + 8'd9) pat = DIGIT_SEGS[4'(lc - ASCII_ZERO)];
    else
      case (lc)
        "a": pat = SEG_A;
        "b": pat = SEG_B;
        "c": pat = SEG_C;
        "d": pat = SEG_D;
        "e": pat = SEG_E;
        "f": pat = SEG_F;
        "-": pat = SEG_DASH;
        " ": pat = SEG_BLANK;
        "_": pat = SEG_UNDERSCORE;
        default: pat = SEG_UNKNOWN;
      endcase
  end
endmodule

// File: rtl/ascii_scan_display.sv
// ascii_scan_display: ASCII character buffer scanned onto a multiplexed 7-segment display.
module ascii_scan_display
  import ascii_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic shift_en,
  output logic [6:0] seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [AW-1:0] LAST_DIGIT = AW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_TICK = PW'(CLK_DIV - 1);
  logic [7:0] chars [NUM_DIGITS];
  logic [PW-1:0] presc;
  logic [6:0] pat;
  logic [NUM_DIGITS-1:0] onehot;
  logic wr_ok;
  assign wr_ok = {1'b0, wr_addr} < (AW + 1)'(NUM_DIGITS);
  assign onehot = NUM_DIGITS'(1) << digit_idx;
  ascii_seg_decode u_decode (.ch(chars[digit_idx]), .pat(pat));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) chars[i] <= ASCII_SPACE;
      presc <= '0;
      digit_idx <= '0;
      seg <= SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
      an <= AN_ACTIVE_LOW ? '1 : '0;
    end else begin
      presc <= (presc == LAST_TICK) ? '0 : presc + 1'b1;
      if (presc == LAST_TICK) digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
      // shift has priority; a simultaneous write is dropped
      if (shift_en) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) chars[i] <= chars[i-1];
        chars[0] <= wr_char;
      end else if (wr_en && wr_ok) chars[wr_addr] <= wr_char;
      seg <= SEG_ACTIVE_LOW ? ~pat : pat;
      an <= AN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end
endmodule

// File: tb/tb_ascii_scan_display.sv
// tb_ascii_scan_display: directed checks of a 4-digit active-low and a 3-digit active-high display.
module tb_ascii_scan_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en4 = 1'b0, shift_en4 = 1'b0;
  logic [1:0] wr_addr4 = '0;
  logic [7:0] wr_char4 = '0;
  logic [6:0] seg4;
  logic [3:0] an4;
  logic [1:0] digit_idx4;
  logic wr_en3 = 1'b0, shift_en3 = 1'b0;
  logic [1:0] wr_addr3 = '0;
  logic [7:0] wr_char3 = '0;
  logic [6:0] seg3;
  logic [2:0] an3;
  logic [1:0] digit_idx3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascii_scan_display #(.NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_char(wr_char4),
    .shift_en(shift_en4), .seg(seg4), .an(an4), .digit_idx(digit_idx4));

  ascii_scan_display #(.NUM_DIGITS(3), .CLK_DIV(2), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_char(wr_char3),
    .shift_en(shift_en3), .seg(seg3), .an(an3), .digit_idx(digit_idx3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write4(input logic [1:0] a, input logic [7:0] c);
    wr_en4 = 1'b1; wr_addr4 = a; wr_char4 = c;
    step();
    wr_en4 = 1'b0;
  endtask

  task automatic shift4(input logic [7:0] c);
    shift_en4 = 1'b1; wr_char4 = c;
    step();
    shift_en4 = 1'b0;
  endtask

  task automatic test_reset();
    int exp_idx;
    logic [3:0] exp_an;
    repeat (3) step();
    checks += 5;
    if (seg4 !== 7'h7F) begin errors++; $display("FAIL reset_seg4 got %h want 7f", seg4); end
    if (an4 !== 4'hF) begin errors++; $display("FAIL reset_an4 got %h want f", an4); end
    if (digit_idx4 !== 2'd0) begin errors++; $display("FAIL reset_idx4 got %0d want 0", digit_idx4); end
    if (seg3 !== 7'h00) begin errors++; $display("FAIL reset_seg3 got %h want 00", seg3); end
    if (an3 !== 3'b000) begin errors++; $display("FAIL reset_an3 got %b want 000", an3); end
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      exp_idx = (n / 4) % 4;
      exp_an = ~(4'b0001 << (((n - 1) / 4) % 4));
      checks += 3;
      if (digit_idx4 !== 2'(exp_idx)) begin errors++; $display("FAIL scan_idx n=%0d got %0d want %0d", n, digit_idx4, exp_idx); end
      if (an4 !== exp_an) begin errors++; $display("FAIL scan_an n=%0d got %h want %h", n, an4, exp_an); end
      if (seg4 !== 7'h7F) begin errors++; $display("FAIL scan_blank n=%0d got %h want 7f", n, seg4); end
    end
  endtask

  task automatic test_decode();
    logic [7:0] txt [3][4] = '{'{"0", "1", "2", "3"}, '{"b", "C", "d", "_"}, '{"E", "f", "a", "B"}};
    logic [6:0] exp [3][4] = '{'{7'h3F, 7'h06, 7'h5B, 7'h4F}, '{7'h7C, 7'h39, 7'h5E, 7'h08}, '{7'h79, 7'h71, 7'h77, 7'h7C}};
    int idx;
    for (int g = 0; g < 3; g++) begin
      for (int a = 0; a < 4; a++) write4(2'(a), txt[g][a]);
      repeat (2) step();
      for (int c = 0; c < 16; c++) begin
        step();
        idx = -1;
        for (int k = 0; k < 4; k++) if (an4 === ~(4'b0001 << k)) idx = k;
        checks++;
        if (idx < 0) begin errors++; $display("FAIL decode_an g=%0d got %h want one-hot low", g, an4); end
        else begin
          checks++;
          if (seg4 !== ~exp[g][idx]) begin errors++; $display("FAIL decode_seg g=%0d digit=%0d got %h want %h", g, idx, seg4, ~exp[g][idx]); end
        end
      end
    end
  endtask

  task automatic test_shift();
    logic [6:0] exp [4] = '{7'h49, 7'h40, 7'h06, 7'h77};
    int idx;
    shift4("A"); shift4("1"); shift4("-"); shift4("z");
    repeat (2) step();
    for (int c = 0; c < 16; c++) begin
      step();
      idx = -1;
      for (int k = 0; k < 4; k++) if (an4 === ~(4'b0001 << k)) idx = k;
      checks++;
      if (idx < 0) begin errors++; $display("FAIL shift_an got %h want one-hot low", an4); end
      else begin
        checks++;
        if (seg4 !== ~exp[idx]) begin errors++; $display("FAIL shift_seg digit=%0d got %h want %h", idx, seg4, ~exp[idx]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [4] = '{7'h6D, 7'h49, 7'h40, 7'h06};
    int idx;
    wr_en4 = 1'b1; shift_en4 = 1'b1; wr_addr4 = 2'd2; wr_char4 = "5";
    step();
    wr_en4 = 1'b0; shift_en4 = 1'b0;
    repeat (2) step();
    for (int c = 0; c < 16; c++) begin
      step();
      idx = -1;
      for (int k = 0; k < 4; k++) if (an4 === ~(4'b0001 << k)) idx = k;
      checks++;
      if (idx < 0) begin errors++; $display("FAIL collide_an got %h want one-hot low", an4); end
      else begin
        checks++;
        if (seg4 !== ~exp[idx]) begin errors++; $display("FAIL collide_seg digit=%0d got %h want %h", idx, seg4, ~exp[idx]); end
      end
    end
  endtask

  task automatic test_async_reset();
    int idx;
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (seg4 !== 7'h7F) begin errors++; $display("FAIL async_seg4 got %h want 7f", seg4); end
    if (an4 !== 4'hF) begin errors++; $display("FAIL async_an4 got %h want f", an4); end
    if (digit_idx4 !== 2'd0) begin errors++; $display("FAIL async_idx4 got %0d want 0", digit_idx4); end
    if (seg3 !== 7'h00) begin errors++; $display("FAIL async_seg3 got %h want 00", seg3); end
    if (an3 !== 3'b000) begin errors++; $display("FAIL async_an3 got %b want 000", an3); end
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 17; c++) begin
      step();
      idx = -1;
      for (int k = 0; k < 4; k++) if (an4 === ~(4'b0001 << k)) idx = k;
      checks += 2;
      if (idx < 0) begin errors++; $display("FAIL post_reset_an got %h want one-hot low", an4); end
      if (seg4 !== 7'h7F) begin errors++; $display("FAIL post_reset_seg got %h want 7f", seg4); end
    end
  endtask

  task automatic test_three_digit();
    logic [2:0] prev_an;
    logic [1:0] prev_idx;
    logic [6:0] exp;
    bit saw_wrap = 1'b0;
    wr_en3 = 1'b1; wr_addr3 = 2'd1; wr_char3 = "9";
    step();
    wr_addr3 = 2'd0; wr_char3 = "z";
    step();
    wr_addr3 = 2'd3; wr_char3 = "0";
    step();
    wr_en3 = 1'b0;
    repeat (2) step();
    prev_an = an3;
    prev_idx = digit_idx3;
    for (int c = 0; c < 18; c++) begin
      step();
      exp = (an3 === 3'b010) ? 7'h6F : (an3 === 3'b001) ? 7'h49 : 7'h00;
      checks += 3;
      if (!$onehot(an3)) begin errors++; $display("FAIL an3_onehot got %b want one-hot high", an3); end
      if (seg3 !== exp) begin errors++; $display("FAIL seg3 an=%b got %h want %h", an3, seg3, exp); end
      if (digit_idx3 > 2'd2) begin errors++; $display("FAIL idx3_range got %0d want <=2", digit_idx3); end
      if (an3 !== prev_an) begin
        checks++;
        if (an3 !== {prev_an[1:0], prev_an[2]}) begin errors++; $display("FAIL an3_order got %b want %b", an3, {prev_an[1:0], prev_an[2]}); end
      end
      if (digit_idx3 !== prev_idx) begin
        checks++;
        if (digit_idx3 !== ((prev_idx == 2'd2) ? 2'd0 : prev_idx + 2'd1)) begin errors++; $display("FAIL idx3_step got %0d after %0d", digit_idx3, prev_idx); end
        if (prev_idx == 2'd2 && digit_idx3 == 2'd0) saw_wrap = 1'b1;
      end
      prev_an = an3;
      prev_idx = digit_idx3;
    end
    checks++;
    if (!saw_wrap) begin errors++; $display("FAIL idx3_wrap got no 2->0 wrap want wrap"); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_shift();
    test_back_to_back();
    test_async_reset();
    test_three_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
